// File: rtl/bin2bcd_funcmod.sv
// ---------------------------------------------------------------------------
// bin2bcd_funcmod
//
// Sequential binary-to-BCD converter feeding the six-digit seven-segment
// display driver. A 20-bit unsigned value is converted by iterative
// shift-and-add-3 (double dabble) into six packed BCD digits. Values above
// 999999 saturate to 999999 and raise oOver.
//
// Ports:
//   CLOCK      in   1   system clock, rising edge
//   RESET      in   1   asynchronous, active-low reset
//   iCall      in   1   start request, sampled only in IDLE
//   iData      in  20   unsigned value to convert, sampled at acceptance
//   oDone      out  1   one-cycle pulse: oData/oOver just updated
//   oBusy      out  1   high from the cycle after acceptance through the
//                       cycle in which oDone is high
//   oData      out 24   packed BCD result, [23:20] hundred-thousands ..
//                       [3:0] units; held between conversions
//   oOver      out  1   last accepted iData exceeded 999999; held with oData
//   dbg_state  out  2   current FSM state (0 IDLE, 1 SHIFT, 2 DONE)
//
// Handshake: a request is accepted on a rising edge where the FSM is IDLE
// and iCall=1 (oBusy low means the converter is ready). iCall is ignored
// while busy; nothing is queued. The result is valid in the single cycle
// oDone is high and remains on oData/oOver until the next oDone. Holding
// iCall high yields back-to-back conversions, one every 22 cycles.
// ---------------------------------------------------------------------------
module bin2bcd_funcmod (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        iCall,
    input  logic [19:0] iData,
    output logic        oDone,
    output logic        oBusy,
    output logic [23:0] oData,
    output logic        oOver,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [19:0] MAX_VAL  = 20'd999999;
    localparam logic [4:0]  LAST_IT  = 5'd19;

    state_t      state;
    state_t      state_nxt;
    logic [19:0] bin_sr;
    logic [23:0] bcd_sr;
    logic [4:0]  cnt;
    logic        over_r;

    logic        accept;
    logic        last_shift;
    logic [23:0] bcd_adj;
    logic [23:0] bcd_shf;
    logic [19:0] src_val;
    logic        src_over;

    assign dbg_state  = state;
    assign accept     = (state == S_IDLE) && iCall;
    assign last_shift = (state == S_SHIFT) && (cnt == LAST_IT);

    // Saturate before conversion so the BCD result never exceeds six digits.
    assign src_over = (iData > MAX_VAL);
    assign src_val  = src_over ? MAX_VAL : iData;

    // Add 3 to every nibble >= 5 so that after the left shift each nibble
    // that would reach 10..19 carries correctly into the next digit.
    always_comb begin
        bcd_adj = bcd_sr;
        for (int i = 0; i < 6; i++) begin
            if (bcd_sr[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
            end
        end
    end

    assign bcd_shf = {bcd_adj[22:0], bin_sr[19]};

    // FSM state register
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (iCall) state_nxt = S_SHIFT;
            S_SHIFT: if (cnt == LAST_IT) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Conversion datapath and shift counter
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            bin_sr <= '0;
            bcd_sr <= '0;
            cnt    <= '0;
            over_r <= 1'b0;
        end else if (accept) begin
            bin_sr <= src_val;
            bcd_sr <= '0;
            cnt    <= '0;
            over_r <= src_over;
        end else if (state == S_SHIFT) begin
            bin_sr <= {bin_sr[18:0], 1'b0};
            bcd_sr <= bcd_shf;
            cnt    <= cnt + 5'd1;
        end
    end

    // Registered outputs; oData/oOver move only on the edge raising oDone,
    // so the display never sees a partial result.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            oData <= '0;
            oOver <= 1'b0;
            oDone <= 1'b0;
            oBusy <= 1'b0;
        end else begin
            oDone <= last_shift;
            if (last_shift) begin
                oData <= bcd_shf;
                oOver <= over_r;
            end
            if (accept) begin
                oBusy <= 1'b1;
            end else if (state == S_DONE) begin
                oBusy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bin2bcd_funcmod.sv
// ---------------------------------------------------------------------------
// Testbench for bin2bcd_funcmod: directed scenarios plus randomized values,
// checked against a decimal-arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_bin2bcd_funcmod;

    logic        CLOCK;
    logic        RESET;
    logic        iCall;
    logic [19:0] iData;
    logic        oDone;
    logic        oBusy;
    logic [23:0] oData;
    logic        oOver;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    logic [24:0] exp_q[$];   // {over, bcd}
    logic [24:0] last_res;   // result the DUT should currently be holding

    bin2bcd_funcmod dut (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .iCall     (iCall),
        .iData     (iData),
        .oDone     (oDone),
        .oBusy     (oBusy),
        .oData     (oData),
        .oOver     (oOver),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic logic [24:0] model(input int unsigned d);
        int unsigned v;
        logic [23:0] r;
        logic        ov;
        ov = (d > 999999);
        v  = ov ? 999999 : d;
        r  = '0;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return {ov, r};
    endfunction

    // ---------------- scoreboard check ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait for oDone within a budget; returns cycles counted after the
    // acceptance cycle (0 on timeout). Checks oData/oOver hold meanwhile.
    task automatic wait_done(input string tag, input int budget, output int lat);
        lat = 0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge CLOCK);
            if (oDone === 1'b1) begin
                lat = c;
                break;
            end
            chk({tag, "_hold"}, {7'd0, oOver, oData}, {7'd0, last_res});
            chk({tag, "_busy_mid"}, {31'd0, oBusy}, 32'd1);
        end
    endtask

    // One complete conversion from IDLE back to IDLE.
    task automatic run_conv(input logic [19:0] d, input string tag);
        int lat;
        logic [24:0] e;
        @(negedge CLOCK);
        iCall = 1'b1;
        iData = d;
        exp_q.push_back(model(d));
        @(negedge CLOCK);              // cycle after accepting edge T
        iCall = 1'b0;
        iData = 20'($urandom);         // must not affect the conversion
        chk({tag, "_busy_start"}, {31'd0, oBusy}, 32'd1);
        chk({tag, "_nodone_start"}, {31'd0, oDone}, 32'd0);
        wait_done(tag, 25, lat);
        chk({tag, "_latency"}, lat, 32'd20);
        e = exp_q.pop_front();
        chk({tag, "_data"}, {8'd0, oData}, {8'd0, e[23:0]});
        chk({tag, "_over"}, {31'd0, oOver}, {31'd0, e[24]});
        chk({tag, "_busy_done"}, {31'd0, oBusy}, 32'd1);
        last_res = e;
        @(negedge CLOCK);              // after T+21
        chk({tag, "_done_fall"}, {31'd0, oDone}, 32'd0);
        chk({tag, "_busy_fall"}, {31'd0, oBusy}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        int gap;
        int ndone;
        logic [19:0] r;

        RESET    = 1'b0;
        iCall    = 1'b0;
        iData    = '0;
        last_res = '0;

        repeat (3) @(negedge CLOCK);
        chk("reset_data",  {8'd0, oData}, 32'd0);
        chk("reset_over",  {31'd0, oOver}, 32'd0);
        chk("reset_done",  {31'd0, oDone}, 32'd0);
        chk("reset_busy",  {31'd0, oBusy}, 32'd0);
        chk("reset_state", {30'd0, dbg_state}, 32'd0);
        RESET = 1'b1;
        repeat (2) @(negedge CLOCK);

        // Directed values, including saturation boundaries
        run_conv(20'd0,       "zero");
        run_conv(20'd123456,  "typical");
        run_conv(20'd999999,  "max");
        run_conv(20'd1000000, "over1");
        run_conv(20'hFFFFF,   "overmax");
        run_conv(20'd9,       "nine");
        run_conv(20'd100000,  "pow10");

        // Busy rejection: second request at T+5 must be ignored
        @(negedge CLOCK);
        iCall = 1'b1;
        iData = 20'd42;
        @(negedge CLOCK);              // after T
        iCall = 1'b0;
        repeat (4) @(negedge CLOCK);   // after T+4
        iCall = 1'b1;
        iData = 20'd777;
        @(negedge CLOCK);              // after T+5
        iCall = 1'b0;
        wait_done("rej", 25, lat);
        chk("rej_latency", lat, 32'd15);
        chk("rej_data", {8'd0, oData}, 32'h000042);
        chk("rej_over", {31'd0, oOver}, 32'd0);
        last_res = model(42);
        ndone = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge CLOCK);
            if (oDone === 1'b1) ndone++;
        end
        chk("rej_no_second_done", ndone, 32'd0);
        chk("rej_idle_busy", {31'd0, oBusy}, 32'd0);
        chk("rej_data_hold", {8'd0, oData}, 32'h000042);

        // Back-to-back with iCall held high
        @(negedge CLOCK);
        iCall = 1'b1;
        iData = 20'd9;
        @(negedge CLOCK);              // after T
        iData = 20'd10;
        wait_done("b2b1", 25, lat);
        chk("b2b1_latency", lat, 32'd20);
        chk("b2b1_data", {8'd0, oData}, 32'h000009);
        last_res = model(9);
        gap = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge CLOCK);
            if (c == 2) iCall = 1'b0;  // second request already accepted
            if (oDone === 1'b1) begin
                gap = c;
                break;
            end
        end
        chk("b2b_gap", gap, 32'd22);
        chk("b2b2_data", {8'd0, oData}, 32'h000010);
        last_res = model(10);
        @(negedge CLOCK);
        chk("b2b_busy_fall", {31'd0, oBusy}, 32'd0);

        // Reset abort mid-conversion
        @(negedge CLOCK);
        iCall = 1'b1;
        iData = 20'd555555;
        @(negedge CLOCK);              // after T
        iCall = 1'b0;
        repeat (9) @(negedge CLOCK);   // after T+9
        RESET = 1'b0;
        #1;
        chk("abort_data", {8'd0, oData}, 32'd0);
        chk("abort_over", {31'd0, oOver}, 32'd0);
        chk("abort_done", {31'd0, oDone}, 32'd0);
        chk("abort_busy", {31'd0, oBusy}, 32'd0);
        repeat (2) @(negedge CLOCK);
        RESET = 1'b1;
        last_res = '0;
        ndone = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge CLOCK);
            if (oDone === 1'b1) ndone++;
        end
        chk("abort_no_done", ndone, 32'd0);
        run_conv(20'd654321, "after_abort");

        // Randomized values over the full range and the legal range
        for (int i = 0; i < 24; i++) begin
            if (i % 2 == 0) r = 20'($urandom_range(0, 20'hFFFFF));
            else            r = 20'($urandom_range(0, 999999));
            run_conv(r, "rand");
        end

        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bin2bcd_funcmod.md
# bin2bcd_funcmod

Sequential binary-to-BCD converter that sits directly upstream of the six-digit seven-segment display driver. It takes a 20-bit unsigned value from the control logic (counters, EEPROM read-back data), converts it by iterative shift-and-add-3 into six packed BCD digits, and holds the result on a 24-bit bus wired straight to the display driver's 24-bit data input. Values above 999999 saturate to 999999 and raise an overflow flag.

## Interface
- No parameters. Input width 20, digit count 6 and iteration count 20 are fixed.
- CLOCK  in  1  system clock; all state changes on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- iCall  in  1  start request; sampled only in IDLE.
- iData  in  20  unsigned binary value to convert.
- oDone  out  1  one-cycle pulse; the oData/oOver update is valid.
- oBusy  out  1  high from the cycle after acceptance until the cycle oDone is high, inclusive.
- oData  out  24  packed BCD, held between conversions. [23:20] hundred-thousands … [3:0] units.
- oOver  out  1  high if the last accepted iData exceeded 999999. Held with oData.

## Operation
- Reset values, applied asynchronously on RESET=0: state IDLE, oData=24'h000000, oOver=0, oDone=0, oBusy=0, iteration counter=0, internal shift registers cleared.
- States:
  - IDLE: if iCall=1, capture the source value into a 20-bit binary shift register and clear the 24-bit BCD accumulator. The source value is iData, or 20'd999999 if iData>999999. Record the overflow bit internally, set the counter to 0, and go to SHIFT. If iCall=0, stay in IDLE.
  - SHIFT: each cycle, first add 3 to every BCD nibble that is ≥5. Then shift {BCD, BIN} left by one bit, taking the BIN MSB into the BCD LSB. Increment the counter. After the 20th SHIFT cycle (counter==19 at the edge), load the adjusted-and-shifted BCD into oData and the overflow bit into oOver, assert oDone, and go to DONE.
  - DONE: oDone=1 for exactly this one cycle. iCall is ignored. Next state is IDLE.
- iCall is ignored in SHIFT and DONE; there is no queueing. Callers drop iCall on oDone.
- If iCall is held high continuously, a new conversion is accepted on the first IDLE cycle after DONE, giving back-to-back operation.
- iData is sampled only at the accepting edge; later changes have no effect on the conversion in flight.
- oData and oOver change only at the edge that raises oDone. Otherwise they hold, so the display never shows partial results.
- Every BCD nibble stays in 0..9 after each shift. No illegal nibble ever reaches oData.
- Reset mid-conversion aborts the conversion: outputs go to reset values, and no oDone is produced for the aborted request.

## Timing
- Accepting edge = edge T at which state is IDLE and iCall=1.
- oBusy=1 from T through T+21.
- oData, oOver and oDone update at edge T+20 and are visible in the cycle after T+20.
- oDone falls at T+21. State returns to IDLE after T+21.
- Earliest next accepting edge: T+22. Throughput is one conversion per 22 cycles.
- Latency is constant at 20 cycles from acceptance to result, independent of value or overflow.
- No combinational path from iCall or iData to any output.

## Test plan
- Zero: reset released, iData=0, iCall pulsed → at T+20 oData=24'h000000, oOver=0, oDone single-cycle high.
- Typical: iData=123456 → oData=24'h123456 exactly 20 edges after acceptance; oData unchanged during SHIFT from its previous value.
- Boundary/saturation:
  - iData=999999 → 24'h999999, oOver=0.
  - iData=1000000 → 24'h999999, oOver=1.
  - iData=20'hFFFFF → 24'h999999, oOver=1.
- Busy rejection: accept iData=42, then pulse iCall with iData=777 at T+5 → only one oDone. oData=24'h000042, and no second conversion starts.
- Back-to-back: iCall held high with iData=9 then 10 → two oDone pulses 22 cycles apart, giving oData=24'h000009 then 24'h000010.
- Reset abort: accept iData=555555, assert RESET at T+10 for 2 cycles → all outputs 0 immediately and no oDone. A fresh request afterwards converts correctly.
